// File: rtl/minesweeper_datapath.sv
// minesweeper_datapath: game-state engine for a COLS x ROWS MineSweeper board.
// Holds mine, flag, step and cursor maps, runs the IDLE/PLAY/WON/LOST machine
// and counts the mines around the cursor cell. Controls are level inputs whose
// rising edges are detected here; at most one event commits per clock edge.
module minesweeper_datapath #(
  parameter int COLS = 8,
  parameter int ROWS = 8,
  parameter int WRAP = 1
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 ldMM,
  input  logic [COLS*ROWS-1:0] MMin,
  input  logic                 ldFM,
  input  logic                 ldSM,
  input  logic                 mv,
  input  logic [1:0]           dir,
  output logic [COLS*ROWS-1:0] MMout,
  output logic [COLS*ROWS-1:0] FMout,
  output logic [COLS*ROWS-1:0] SMout,
  output logic [COLS*ROWS-1:0] PMout,
  output logic [3:0]           cur_x,
  output logic [3:0]           cur_y,
  output logic [3:0]           adj_cnt,
  output logic                 win,
  output logic                 lose
);

  localparam int N  = COLS * ROWS;
  localparam int IW = $clog2(N);

  typedef enum logic [1:0] {IDLE, PLAY, WON, LOST} state_t;

  state_t        state;
  state_t        state_nx;
  logic          ldMM_d;
  logic          ldFM_d;
  logic          ldSM_d;
  logic          mv_d;
  logic          ev_mm;
  logic          ev_sm;
  logic          ev_fm;
  logic          ev_mv;
  logic          all_done;
  logic [IW-1:0] idx;
  logic [3:0]    x_nx;
  logic [3:0]    y_nx;

  // Delay each control by one clock so a rising edge can be recognised
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ldMM_d <= 1'b0;
      ldFM_d <= 1'b0;
      ldSM_d <= 1'b0;
      mv_d   <= 1'b0;
    end else begin
      ldMM_d <= ldMM;
      ldFM_d <= ldFM;
      ldSM_d <= ldSM;
      mv_d   <= mv;
    end
  end

  // Prioritised events (ldMM > ldSM > ldFM > mv), cursor index and win condition
  always_comb begin
    ev_mm    = ldMM & ~ldMM_d;
    ev_sm    = ldSM & ~ldSM_d & ~ev_mm;
    ev_fm    = ldFM & ~ldFM_d & ~ev_mm & ~ev_sm;
    ev_mv    = mv & ~mv_d & ~ev_mm & ~ev_sm & ~ev_fm;
    idx      = IW'(int'(cur_y) * COLS + int'(cur_x));
    all_done = &(SMout | MMout);
  end

  // Candidate cursor position for a move; wraps or saturates at the grid edge
  always_comb begin
    x_nx = cur_x;
    y_nx = cur_y;
    unique case (dir)
      2'b00: begin
        if (cur_x == 4'(COLS - 1)) x_nx = (WRAP != 0) ? 4'd0 : cur_x;
        else                       x_nx = cur_x + 4'd1;
      end
      2'b01: begin
        if (cur_x == 4'd0) x_nx = (WRAP != 0) ? 4'(COLS - 1) : cur_x;
        else               x_nx = cur_x - 4'd1;
      end
      2'b10: begin
        if (cur_y == 4'(ROWS - 1)) y_nx = (WRAP != 0) ? 4'd0 : cur_y;
        else                       y_nx = cur_y + 4'd1;
      end
      2'b11: begin
        if (cur_y == 4'd0) y_nx = (WRAP != 0) ? 4'(ROWS - 1) : cur_y;
        else               y_nx = cur_y - 4'd1;
      end
    endcase
  end

  // Board maps and cursor: a load restarts the game, play events only act in PLAY
  // while the board is not yet complete (a complete board moves to WON instead)
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      MMout <= '0;
      FMout <= '0;
      SMout <= '0;
      cur_x <= 4'd0;
      cur_y <= 4'd0;
    end else if (ev_mm) begin
      MMout <= MMin;
      FMout <= '0;
      SMout <= '0;
      cur_x <= 4'd0;
      cur_y <= 4'd0;
    end else if (state == PLAY && !all_done) begin
      if (ev_sm) begin
        if (!FMout[idx]) SMout[idx] <= 1'b1;
      end else if (ev_fm) begin
        if (!SMout[idx]) FMout[idx] <= ~FMout[idx];
      end else if (ev_mv) begin
        cur_x <= x_nx;
        cur_y <= y_nx;
      end
    end
  end

  // Game state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nx;
  end

  // Next-state: load from anywhere, completion wins, stepping an unflagged mine loses
  always_comb begin
    state_nx = state;
    if (ev_mm) begin
      state_nx = PLAY;
    end else if (state == PLAY) begin
      if (all_done)                               state_nx = WON;
      else if (ev_sm && !FMout[idx] && MMout[idx]) state_nx = LOST;
    end
  end

  // Status outputs decoded from the registered state
  always_comb begin
    win  = (state == WON);
    lose = (state == LOST);
  end

  // One-hot cursor map
  always_comb begin
    PMout      = '0;
    PMout[idx] = 1'b1;
  end

  // Mines among the in-grid neighbours of the cursor; counting never wraps
  always_comb begin
    int nx;
    int ny;
    nx      = 0;
    ny      = 0;
    adj_cnt = 4'd0;
    for (int dy = -1; dy <= 1; dy++) begin
      for (int dx = -1; dx <= 1; dx++) begin
        nx = int'(cur_x) + dx;
        ny = int'(cur_y) + dy;
        if (!(dx == 0 && dy == 0) && nx >= 0 && nx < COLS && ny >= 0 && ny < ROWS) begin
          if (MMout[IW'(ny * COLS + nx)]) adj_cnt = adj_cnt + 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_minesweeper_datapath.sv
// Bench for minesweeper_datapath: an 8x8 wrapping board and a 5x3 saturating
// board share the control inputs; a behavioural game model predicts every
// post-edge output into per-board queues that a monitor drains and compares.
module tb_minesweeper_datapath;

  logic        clk;
  logic        resetn;
  logic        ldMM;
  logic        ldFM;
  logic        ldSM;
  logic        mv;
  logic [1:0]  dir;
  logic [63:0] mm0_in;
  logic [14:0] mm1_in;

  logic [63:0] mmo0, fmo0, smo0, pmo0;
  logic [3:0]  cx0, cy0, adj0;
  logic        win0, lose0;
  logic [14:0] mmo1, fmo1, smo1, pmo1;
  logic [3:0]  cx1, cy1, adj1;
  logic        win1, lose1;

  minesweeper_datapath #(.COLS(8), .ROWS(8), .WRAP(1)) u0 (
    .clk(clk), .resetn(resetn), .ldMM(ldMM), .MMin(mm0_in), .ldFM(ldFM), .ldSM(ldSM),
    .mv(mv), .dir(dir), .MMout(mmo0), .FMout(fmo0), .SMout(smo0), .PMout(pmo0),
    .cur_x(cx0), .cur_y(cy0), .adj_cnt(adj0), .win(win0), .lose(lose0)
  );

  minesweeper_datapath #(.COLS(5), .ROWS(3), .WRAP(0)) u1 (
    .clk(clk), .resetn(resetn), .ldMM(ldMM), .MMin(mm1_in), .ldFM(ldFM), .ldSM(ldSM),
    .mv(mv), .dir(dir), .MMout(mmo1), .FMout(fmo1), .SMout(smo1), .PMout(pmo1),
    .cur_x(cx1), .cur_y(cy1), .adj_cnt(adj1), .win(win1), .lose(lose1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] mm, fm, sm, pm;
    int          x, y, adj;
    logic        win, lose;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   checks = 0;
  int   errors = 0;

  // Game model: plain arrays of cells, state as 0 idle, 1 play, 2 won, 3 lost
  int          g_cols[2] = '{8, 5};
  int          g_rows[2] = '{8, 3};
  int          g_wrap[2] = '{1, 0};
  logic [63:0] m_mm[2], m_fm[2], m_sm[2];
  int          m_x[2], m_y[2], m_st[2];
  logic        p_mm, p_fm, p_sm, p_mv;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %h expected %h", nm, act, want);
    end
  endtask

  function automatic int adj_of(input int k);
    int c = 0;
    for (int dy = -1; dy <= 1; dy++)
      for (int dx = -1; dx <= 1; dx++) begin
        int nx = m_x[k] + dx;
        int ny = m_y[k] + dy;
        if ((dx != 0 || dy != 0) && nx >= 0 && nx < g_cols[k] && ny >= 0 && ny < g_rows[k])
          if (m_mm[k][ny * g_cols[k] + nx]) c++;
      end
    return c;
  endfunction

  // Predict the effect of the coming clock edge with the inputs now applied
  task automatic model_edge();
    logic e_mm, e_sm, e_fm, e_mv;
    if (!resetn) begin
      for (int k = 0; k < 2; k++) begin
        m_mm[k] = '0; m_fm[k] = '0; m_sm[k] = '0;
        m_x[k] = 0; m_y[k] = 0; m_st[k] = 0;
      end
      p_mm = 0; p_fm = 0; p_sm = 0; p_mv = 0;
      return;
    end
    e_mm = ldMM && !p_mm;
    e_sm = ldSM && !p_sm;
    e_fm = ldFM && !p_fm;
    e_mv = mv && !p_mv;
    p_mm = ldMM; p_sm = ldSM; p_fm = ldFM; p_mv = mv;
    for (int k = 0; k < 2; k++) begin
      int c = g_cols[k];
      int r = g_rows[k];
      int i = m_y[k] * c + m_x[k];
      if (e_mm) begin
        m_mm[k] = (k == 0) ? mm0_in : 64'(mm1_in);
        m_fm[k] = '0; m_sm[k] = '0;
        m_x[k] = 0; m_y[k] = 0; m_st[k] = 1;
      end else if (m_st[k] == 1) begin
        bit done = 1;
        for (int j = 0; j < c * r; j++)
          if (!m_sm[k][j] && !m_mm[k][j]) done = 0;
        if (done) m_st[k] = 2;
        else if (e_sm) begin
          if (!m_fm[k][i] && !m_sm[k][i]) begin
            m_sm[k][i] = 1'b1;
            if (m_mm[k][i]) m_st[k] = 3;
          end
        end else if (e_fm) begin
          if (!m_sm[k][i]) m_fm[k][i] = !m_fm[k][i];
        end else if (e_mv) begin
          case (dir)
            2'b00: m_x[k] = (m_x[k] < c - 1) ? m_x[k] + 1 : (g_wrap[k] != 0 ? 0 : m_x[k]);
            2'b01: m_x[k] = (m_x[k] > 0) ? m_x[k] - 1 : (g_wrap[k] != 0 ? c - 1 : m_x[k]);
            2'b10: m_y[k] = (m_y[k] < r - 1) ? m_y[k] + 1 : (g_wrap[k] != 0 ? 0 : m_y[k]);
            default: m_y[k] = (m_y[k] > 0) ? m_y[k] - 1 : (g_wrap[k] != 0 ? r - 1 : m_y[k]);
          endcase
        end
      end
    end
  endtask

  function automatic exp_t expect_of(input int k);
    exp_t e;
    e.mm   = m_mm[k];
    e.fm   = m_fm[k];
    e.sm   = m_sm[k];
    e.pm   = 64'd1 << (m_y[k] * g_cols[k] + m_x[k]);
    e.x    = m_x[k];
    e.y    = m_y[k];
    e.adj  = adj_of(k);
    e.win  = (m_st[k] == 2);
    e.lose = (m_st[k] == 3);
    return e;
  endfunction

  // One clock: predict, queue the expectation, then let the edge happen
  task automatic step();
    model_edge();
    q0.push_back(expect_of(0));
    q1.push_back(expect_of(1));
    @(posedge clk);
    #2;
  endtask

  task automatic press_sm(); ldSM = 1; step(); ldSM = 0; step(); endtask
  task automatic press_fm(); ldFM = 1; step(); ldFM = 0; step(); endtask
  task automatic move(input logic [1:0] d); dir = d; mv = 1; step(); mv = 0; step(); endtask
  task automatic load(input logic [63:0] a, input logic [14:0] b);
    mm0_in = a; mm1_in = b; ldMM = 1; step(); ldMM = 0; step();
  endtask

  // Monitor: compare every board output shortly after each active edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0) begin
        e = q0.pop_front();
        chk("u0.MMout", mmo0, e.mm);
        chk("u0.FMout", fmo0, e.fm);
        chk("u0.SMout", smo0, e.sm);
        chk("u0.PMout", pmo0, e.pm);
        chk("u0.cur_x", 64'(cx0), 64'(e.x));
        chk("u0.cur_y", 64'(cy0), 64'(e.y));
        chk("u0.adj_cnt", 64'(adj0), 64'(e.adj));
        chk("u0.win_lose", {62'd0, win0, lose0}, {62'd0, e.win, e.lose});
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        chk("u1.MMout", 64'(mmo1), e.mm);
        chk("u1.FMout", 64'(fmo1), e.fm);
        chk("u1.SMout", 64'(smo1), e.sm);
        chk("u1.PMout", 64'(pmo1), e.pm);
        chk("u1.cur_x", 64'(cx1), 64'(e.x));
        chk("u1.cur_y", 64'(cy1), 64'(e.y));
        chk("u1.adj_cnt", 64'(adj1), 64'(e.adj));
        chk("u1.win_lose", {62'd0, win1, lose1}, {62'd0, e.win, e.lose});
      end
    end
  end

  initial begin
    resetn = 0; ldMM = 0; ldFM = 0; ldSM = 0; mv = 0; dir = 2'b00;
    mm0_in = '0; mm1_in = '0;
    step(); step();
    chk("reset.PMout", pmo0, 64'd1);
    resetn = 1;
    step();

    // Events before any load are ignored in IDLE
    press_sm(); press_fm(); move(2'b00);
    chk("idle.cur_x", 64'(cx0), 64'd0);

    // Reset in the middle of a game with a flag placed
    load(64'h0000_0000_0000_0100, 15'h0004);
    move(2'b00); press_fm();
    chk("play.FMout", fmo0, 64'h2);
    resetn = 0; step();
    chk("rst.FMout", fmo0, 64'd0);
    chk("rst.MMout", mmo0, 64'd0);
    chk("rst.PMout", pmo0, 64'd1);
    chk("rst.win_lose", {62'd0, win0, lose0}, 64'd0);
    ldMM = 1; mm0_in = 64'h8000_0000_0000_0000; step();
    resetn = 1; step();
    chk("held_ldMM.MMout", mmo0, 64'h8000_0000_0000_0000);
    ldMM = 0; step();

    // Left move at (0,0): wraps on the 8x8 board, saturates on the 5x3 board
    load(64'h0, 15'h0805);
    chk("adj.corner", 64'(adj1), 64'd0);
    move(2'b01);
    chk("wrap.cur_x", 64'(cx0), 64'd7);
    chk("wrap.cur_y", 64'(cy0), 64'd0);
    chk("wrap.PMout", pmo0, 64'h80);
    chk("sat.cur_x", 64'(cx1), 64'd0);
    move(2'b00); move(2'b10);
    chk("adj.center", 64'(adj1), 64'd3);

    // Flagged mine cannot be stepped; unflagged step loses and freezes the board
    load(64'h200, 15'h0);
    move(2'b00); move(2'b10);
    press_fm();
    chk("flag.FMout", fmo0, 64'h200);
    press_sm();
    chk("flagged_step.SMout", smo0, 64'h0);
    press_fm(); press_sm();
    chk("step.SMout", smo0, 64'h200);
    chk("step.lose", 64'(lose0), 64'd1);
    move(2'b00);
    chk("lost.cur_x", 64'(cx0), 64'd1);

    // Sweep every safe cell of a board with one mine in the top-left corner
    load(64'h1, 15'h0);
    for (int y = 0; y < 8; y++) begin
      for (int x = 0; x < 8; x++) begin
        if (x == 7 && y == 7) begin
          ldSM = 1; step();
          chk("win.same_edge", 64'(win0), 64'd0);
          ldSM = 0; step();
          chk("win.next_edge", 64'(win0), 64'd1);
        end else begin
          if (!(x == 0 && y == 0)) press_sm();
          move(2'b00);
          if (x == 7) move(2'b10);
        end
      end
    end

    // Simultaneous step and move edges: step wins; a held step fires once
    load(64'h8000_0000_0000_0000, 15'h7FFF);
    ldSM = 1; mv = 1; dir = 2'b00; step();
    mv = 0;
    for (int i = 0; i < 9; i++) step();
    ldSM = 0; step();
    chk("prio.cur_x", 64'(cx0), 64'd0);
    chk("prio.SMout", smo0, 64'd1);
    chk("all_mine.win", 64'(win1), 64'd1);

    // Randomised play
    for (int n = 0; n < 2500; n++) begin
      resetn = ($urandom_range(0, 399) != 0);
      ldMM   = ($urandom_range(0, 59) == 0);
      ldSM   = ($urandom_range(0, 3) == 0);
      ldFM   = ($urandom_range(0, 4) == 0);
      mv     = ($urandom_range(0, 1) == 0);
      dir    = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0) begin
        mm0_in = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
        mm1_in = 15'($urandom) & 15'($urandom);
      end else begin
        mm0_in = ~({$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom});
        mm1_in = ~(15'($urandom) & 15'($urandom) & 15'($urandom));
      end
      step();
    end

    ldMM = 0; ldSM = 0; ldFM = 0; mv = 0; resetn = 1;
    step(); step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
